// File: rtl/truth_table_lut_seq_pkg.sv
// Shared types and helpers for the truth-table evaluator and its
// serial table loader.
package truth_table_pkg;

    localparam int MAX_N_IN = 6;

    typedef enum logic {
        IDLE,
        LOAD
    } cfg_state_t;

    // Row 0 maps to the table MSB, so row r lives at bit (tt_w-1-r).
    function automatic logic row_bit(input logic [63:0] tt, input int tt_w, input int r);
        logic [5:0] idx;
        idx = 6'(tt_w - 1 - r);
        return tt[idx];
    endfunction

endpackage

// File: rtl/truth_table_lut_seq_if.sv
// Valid/ready evaluation stream between an input-sample source and the
// truth-table evaluator.
interface truth_table_lut_seq_if #(
    parameter int N_IN = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_vec;
    logic            out_valid;
    logic            out_ready;
    logic            out_bit;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_bit
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_bit
    );
endinterface

// File: rtl/truth_table_lut_seq_cfg_loader.sv
// Serial truth-table loader: collects TT_W bits (row 0 first) into a
// shadow register and commits them to the active table atomically.
module tt_cfg_loader
    import truth_table_pkg::*;
#(
    parameter int              N_IN    = 3,
    parameter int              TT_W    = 2 ** N_IN,
    parameter logic [TT_W-1:0] INIT_TT = 8'hAB
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    input  logic            cfg_abort,
    output logic            cfg_busy,
    output logic            cfg_done,
    output logic [TT_W-1:0] tt_active
);

    localparam int CNT_W = $clog2(TT_W) + 1;

    cfg_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [TT_W-1:0]  shadow;
    logic [TT_W-1:0]  shadow_next;

    // NOTE: default assignment first so every path assigns shadow_next and no latch is inferred.
    always_comb begin
        shadow_next = shadow;
        for (int i = 0; i < TT_W; i++) begin
            if (i == TT_W - 1 - int'(cnt)) shadow_next[i] = cfg_bit;
        end
    end

    assign cfg_busy = (state == LOAD);

    // NOTE: sequential state uses non-blocking assignments; the shadow is a plain
    // register (not a memory array), so it is cleared on reset like everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            tt_active <= INIT_TT;
            cfg_done  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_abort) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        shadow <= '0;
                    end else if (cfg_start) begin
                        cnt    <= '0;
                        shadow <= '0;
                    end else if (cfg_valid) begin
                        shadow <= shadow_next;
                        if (cnt == CNT_W'(TT_W - 1)) begin
                            // Last bit: commit including the bit arriving this cycle.
                            tt_active <= shadow_next;
                            cfg_done  <= 1'b1;
                            state     <= IDLE;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/truth_table_lut_seq.sv
// N-input single-output logic function evaluator with a run-time
// reprogrammable truth table and a one-stage registered valid/ready output.
module truth_table_lut_seq
    import truth_table_pkg::*;
#(
    parameter int              N_IN    = 3,
    parameter int              TT_W    = 2 ** N_IN,
    parameter logic [TT_W-1:0] INIT_TT = 8'hAB
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_lut_seq_if.slave   s_if,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    input  logic                   cfg_abort,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic [TT_W-1:0]        tt_active
);

    logic accept;
    logic lookup;

    tt_cfg_loader #(
        .N_IN    (N_IN),
        .TT_W    (TT_W),
        .INIT_TT (INIT_TT)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_abort (cfg_abort),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .tt_active (tt_active)
    );

    assign s_if.in_ready = !s_if.out_valid || s_if.out_ready;
    assign accept        = s_if.in_valid && s_if.in_ready;
    // A commit lands on the same edge, so an accept in that cycle sees the old table.
    assign lookup        = row_bit(64'(tt_active), TT_W, int'(s_if.in_vec));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_if.out_valid <= 1'b0;
            s_if.out_bit   <= 1'b0;
        end else if (accept) begin
            s_if.out_valid <= 1'b1;
            s_if.out_bit   <= lookup;
        end else if (s_if.out_ready) begin
            s_if.out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/truth_table_lut_seq.md
Name: truth_table_lut_seq

Overview:
- Parametrised N-input single-output logic function evaluator; successor to the fixed 3-input hex-truth-table gate modules.
- Truth table is held in a register, initialised from a parameter and reprogrammable at run time through a serial load port.
- Evaluation uses a valid/ready stream with a one-stage registered output.
- Sits between input-sample streams and downstream gate/circuit models, so one instance covers every 2^(2^N) function.

Parameters:
- N_IN, 3, number of logic inputs (1..6).
- TT_W, 2**N_IN, truth-table width (derived; do not override).
- INIT_TT, 8'hAB, reset truth table, hex notation (MSB = row 0).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept input.
- in_vec  in  N_IN  input vector; in_vec[N_IN-1] is in1, the MSB of the row index.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_bit  out  1  function value.
- cfg_start  in  1  begin table load (pulse).
- cfg_valid  in  1  cfg_bit is valid this cycle.
- cfg_bit  in  1  next table bit, row 0 first.
- cfg_abort  in  1  discard load in progress.
- cfg_busy  out  1  load in progress.
- cfg_done  out  1  one-cycle pulse on commit.
- tt_active  out  TT_W  current active table.

Behaviour:
- Row index r = in_vec, unsigned. Result = tt_active[TT_W-1-r], so row 000 maps to the table MSB. Example: INIT_TT 0xAB gives 000→1, 001→0, 111→1.
- Reset (async assert): tt_active=INIT_TT, out_valid=0, out_bit=0, cfg_busy=0, cfg_done=0, bit counter=0, shadow=0, FSM=IDLE.
- Eval handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - On in_valid && in_ready: out_bit <= lookup, out_valid <= 1. Latency 1 cycle.
  - On out_ready && out_valid with no new accept: out_valid <= 0.
  - While out_valid && !out_ready: out_bit is held stable.
  - Full throughput: one result per cycle when out_ready stays high.
- Config FSM, states IDLE and LOAD:
  - IDLE: cfg_start → LOAD, counter=0. cfg_valid and cfg_abort are ignored.
  - LOAD: each cfg_valid writes cfg_bit into shadow[TT_W-1-counter] and increments counter. On the bit where counter==TT_W-1: tt_active <= shadow with the last bit included, cfg_done pulses the next cycle, FSM → IDLE.
  - LOAD, cfg_abort: → IDLE, no commit, shadow is discarded. Abort wins over a same-cycle cfg_valid.
  - LOAD, cfg_start: restarts, counter=0, and the same-cycle cfg_valid is ignored.
  - cfg_busy = (state==LOAD).
- Table coherency:
  - Evaluations during LOAD use the old table.
  - An evaluation accepted in the commit cycle uses the old table; the new table applies from the next accepted input.
  - The output register is not rewritten on commit.
- Counter width is clog2(TT_W)+1 and never wraps. Commit occurs exactly at TT_W bits.
- Reset mid-load: the load is lost, tt_active returns to INIT_TT, and any pending out_valid is dropped.

Decomposition:
- Package truth_table_pkg:
  - cfg_state_t enum {IDLE, LOAD};
  - function row_bit(tt, r) returning tt[TT_W-1-r];
  - constant MAX_N_IN=6.
- Sub-module tt_cfg_loader holds the FSM, counter, shadow and commit strobe, and outputs the tt_active register.
- The top level holds the eval pipeline register and the handshake.

Test Plan:
- Reset defaults, N_IN=3, INIT 0xAB: stream 000..111 with out_ready=1 → out_bit 1,0,1,0,1,0,1,1, one per cycle after 1-cycle latency.
- Serial load of 0x69 (bits 0,1,1,0,1,0,0,1) → cfg_done one cycle after the 8th bit, tt_active=0x69; then 001→1, 011→0, 111→1.
- Backpressure: out_ready=0 for 3 cycles after accepting 001 → in_ready=0, out_bit=0 held, the next input is not consumed; release → next result follows.
- Abort after 4 load bits → cfg_busy falls, tt_active stays 0xAB, 001→0. A cfg_start mid-load followed by 8 bits of 0x80 → tt_active=0x80.
- Commit-cycle collision: input 000 accepted in the same cycle as the last bit of 0x00 → result 1 (old table); the next input 000 → 0.
- Async rst asserted mid-load with out_valid=1 → out_valid=0, cfg_busy=0, tt_active=0xAB immediately, without waiting for a clock edge.
